// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: format codes, core opcodes,
// instruction field positions and the immediate range-check helper.
package inst_encoder_pkg;

    // Request format selector as presented on the fmt port.
    typedef enum logic [2:0] {
        FmtR    = 3'd0,
        FmtI    = 3'd1,
        FmtS    = 3'd2,
        FmtB    = 3'd3,
        FmtU    = 3'd4,
        FmtJ    = 3'd5,
        FmtCsr  = 3'd6,
        FmtRsvd = 3'd7
    } fmt_e;

    // Core RV32I major opcodes.
    typedef enum logic [6:0] {
        OpcLoad   = 7'b0000011,
        OpcOpImm  = 7'b0010011,
        OpcAuipc  = 7'b0010111,
        OpcStore  = 7'b0100011,
        OpcOp     = 7'b0110011,
        OpcLui    = 7'b0110111,
        OpcBranch = 7'b1100011,
        OpcJalr   = 7'b1100111,
        OpcJal    = 7'b1101111,
        OpcSystem = 7'b1110011
    } opcode_e;

    // Field widths.
    localparam int unsigned InstW    = 32;
    localparam int unsigned OpcodeW  = 7;
    localparam int unsigned RegW     = 5;
    localparam int unsigned Funct3W  = 3;
    localparam int unsigned Funct7W  = 7;
    localparam int unsigned ImmW     = 32;

    // Field slice positions inside the instruction word.
    localparam int unsigned OpcodeLsb = 0;
    localparam int unsigned RdLsb     = 7;
    localparam int unsigned Funct3Lsb = 12;
    localparam int unsigned Rs1Lsb    = 15;
    localparam int unsigned Rs2Lsb    = 20;
    localparam int unsigned Funct7Lsb = 25;
    localparam int unsigned ImmILsb   = 20;
    localparam int unsigned ImmULsb   = 12;

    // One encode request as captured by the first pipeline stage.
    typedef struct packed {
        fmt_e                 fmt;
        logic [OpcodeW-1:0]   opcode;
        logic [RegW-1:0]      rd;
        logic [RegW-1:0]      rs1;
        logic [RegW-1:0]      rs2;
        logic [Funct3W-1:0]   funct3;
        logic [Funct7W-1:0]   funct7;
        logic [ImmW-1:0]      imm;
    } enc_req_t;

    // True when v[31:msb] are all equal, i.e. v is representable as an (msb+1)-bit
    // two's complement value.
    function automatic logic fits_signed(input logic [ImmW-1:0] v, input int unsigned msb);
        logic [ImmW-1:0] s;
        s = $signed(v) >>> msb;
        return (s == '0) || (s == '1);
    endfunction

    // Immediate out-of-range / misalignment check; reserved format is always an error.
    function automatic logic imm_err(input fmt_e f, input logic [ImmW-1:0] imm);
        logic e;
        e = 1'b0;
        unique case (f)
            FmtR:    e = 1'b0;
            FmtI:    e = !fits_signed(imm, 11);
            FmtS:    e = !fits_signed(imm, 11);
            FmtB:    e = !fits_signed(imm, 12) || imm[0];
            FmtU:    e = |imm[11:0];
            FmtJ:    e = !fits_signed(imm, 20) || imm[0];
            FmtCsr:  e = |imm[31:5];
            FmtRsvd: e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/inst_field_pack.sv
// Combinational field packer: format + fields -> RV32I word and range-error flag.
// Error detection is compiled in only when INST_ENC_RANGE_CHK_EN is defined; otherwise
// err_o is tied low and out-of-range immediates are silently truncated.
module inst_field_pack
    import inst_encoder_pkg::*;
(
    input  enc_req_t          req_i,
    output logic [InstW-1:0]  inst_o,
    output logic              err_o
);

    // Place each field at its slot; immediates are scattered as the inverse of core decode.
    always_comb begin
        inst_o = '0;
        inst_o[OpcodeLsb +: OpcodeW] = req_i.opcode;
        unique case (req_i.fmt)
            FmtR: begin
                inst_o[RdLsb +: RegW]         = req_i.rd;
                inst_o[Funct3Lsb +: Funct3W]  = req_i.funct3;
                inst_o[Rs1Lsb +: RegW]        = req_i.rs1;
                inst_o[Rs2Lsb +: RegW]        = req_i.rs2;
                inst_o[Funct7Lsb +: Funct7W]  = req_i.funct7;
            end
            FmtI: begin
                inst_o[RdLsb +: RegW]         = req_i.rd;
                inst_o[Funct3Lsb +: Funct3W]  = req_i.funct3;
                inst_o[Rs1Lsb +: RegW]        = req_i.rs1;
                inst_o[ImmILsb +: 12]         = req_i.imm[11:0];
            end
            FmtS: begin
                inst_o[RdLsb +: RegW]         = req_i.imm[4:0];
                inst_o[Funct3Lsb +: Funct3W]  = req_i.funct3;
                inst_o[Rs1Lsb +: RegW]        = req_i.rs1;
                inst_o[Rs2Lsb +: RegW]        = req_i.rs2;
                inst_o[Funct7Lsb +: Funct7W]  = req_i.imm[11:5];
            end
            FmtB: begin
                inst_o[RdLsb]                 = req_i.imm[11];
                inst_o[RdLsb + 1 +: 4]        = req_i.imm[4:1];
                inst_o[Funct3Lsb +: Funct3W]  = req_i.funct3;
                inst_o[Rs1Lsb +: RegW]        = req_i.rs1;
                inst_o[Rs2Lsb +: RegW]        = req_i.rs2;
                inst_o[Funct7Lsb +: 6]        = req_i.imm[10:5];
                inst_o[InstW - 1]             = req_i.imm[12];
            end
            FmtU: begin
                inst_o[RdLsb +: RegW]         = req_i.rd;
                inst_o[ImmULsb +: 20]         = req_i.imm[31:12];
            end
            FmtJ: begin
                inst_o[RdLsb +: RegW]         = req_i.rd;
                inst_o[ImmULsb +: 8]          = req_i.imm[19:12];
                inst_o[ImmULsb + 8]           = req_i.imm[11];
                inst_o[ImmULsb + 9 +: 10]     = req_i.imm[10:1];
                inst_o[InstW - 1]             = req_i.imm[20];
            end
            FmtCsr: begin
                // {funct7, rs2} carry the CSR address; the rs1 slot holds the zimm.
                inst_o[RdLsb +: RegW]         = req_i.rd;
                inst_o[Funct3Lsb +: Funct3W]  = req_i.funct3;
                inst_o[Rs1Lsb +: RegW]        = req_i.imm[4:0];
                inst_o[Rs2Lsb +: RegW]        = req_i.rs2;
                inst_o[Funct7Lsb +: Funct7W]  = req_i.funct7;
            end
            FmtRsvd: begin
                // Only the opcode survives.
            end
        endcase
    end

`ifdef INST_ENC_RANGE_CHK_EN
    assign err_o = imm_err(req_i.fmt, req_i.imm);
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: 2-stage valid/ready pipeline. Stage 1 registers the request,
// stage 2 registers the packed word and its error flag. Optional range checking and the
// saturating error counter are enabled with INST_ENC_RANGE_CHK_EN.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            fmt,
    input  logic [6:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [31:0]           imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           inst,
    output logic                  err,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    enc_req_t          in_req;
    enc_req_t          s1_req_d, s1_req_q;
    logic              s1_valid_d, s1_valid_q;
    logic              s2_valid_d, s2_valid_q;
    logic [InstW-1:0]  s2_inst_d, s2_inst_q;
    logic              s2_err_d, s2_err_q;
    logic [InstW-1:0]  pack_inst;
    logic              pack_err;
    logic              s2_ready;
    logic              s1_adv;
    logic              accept;

    // Bundle the request ports into one struct.
    always_comb begin
        in_req        = '0;
        in_req.fmt    = fmt_e'(fmt);
        in_req.opcode = opcode;
        in_req.rd     = rd;
        in_req.rs1    = rs1;
        in_req.rs2    = rs2;
        in_req.funct3 = funct3;
        in_req.funct7 = funct7;
        in_req.imm    = imm;
    end

    inst_field_pack u_field_pack (
        .req_i  (s1_req_q),
        .inst_o (pack_inst),
        .err_o  (pack_err)
    );

    // Handshake and stage next-state: a stage loads when its successor is empty or draining.
    always_comb begin
        s2_ready   = !s2_valid_q || out_ready;
        s1_adv     = s1_valid_q && s2_ready;
        in_ready   = !s1_valid_q || s1_adv;
        accept     = in_valid && in_ready;

        s1_valid_d = s1_valid_q;
        s1_req_d   = s1_req_q;
        s2_valid_d = s2_valid_q;
        s2_inst_d  = s2_inst_q;
        s2_err_d   = s2_err_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_req_d   = in_req;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_inst_d  = pack_inst;
            s2_err_d   = pack_err;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // Pipeline registers; reset drops any in-flight words.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_req_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_inst_q  <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_req_q   <= s1_req_d;
            s2_valid_q <= s2_valid_d;
            s2_inst_q  <= s2_inst_d;
            s2_err_q   <= s2_err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign inst      = s2_inst_q;
    assign err       = s2_err_q;

`ifdef INST_ENC_RANGE_CHK_EN
    logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;

    // Count delivered error words, holding at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (s2_valid_q && out_ready && s2_err_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed literal cases plus randomized traffic
// with random backpressure and resets, scored against a behavioural encoder model.
module tb_inst_encoder;

    localparam int unsigned CntW = 8;
    localparam int unsigned CntMax = (1 << CntW) - 1;
`ifdef INST_ENC_RANGE_CHK_EN
    localparam logic Chk = 1'b1;
`else
    localparam logic Chk = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      fmt = '0;
    logic [6:0]      opcode = '0;
    logic [4:0]      rd = '0;
    logic [4:0]      rs1 = '0;
    logic [4:0]      rs2 = '0;
    logic [2:0]      funct3 = '0;
    logic [6:0]      funct7 = '0;
    logic [31:0]     imm = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [31:0]     inst;
    logic            err;
    logic [CntW-1:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    inst_encoder #(.ERR_CNT_W(CntW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst      (inst),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoder from the format rules, using plain shifts and signed ranges.
    function automatic exp_t model(input logic [2:0] f, input logic [6:0] op,
                                   input logic [4:0] d, input logic [4:0] a,
                                   input logic [4:0] b, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] im);
        exp_t r;
        int si;
        logic [31:0] o, vd, v1, v2, v3, v7;
        si = int'(im);
        o  = 32'(op);
        vd = 32'(d) << 7;
        v3 = 32'(f3) << 12;
        v1 = 32'(a) << 15;
        v2 = 32'(b) << 20;
        v7 = 32'(f7) << 25;
        case (f)
            3'd0: begin r.inst = v7 | v2 | v1 | v3 | vd | o; r.err = 1'b0; end
            3'd1: begin
                r.inst = ((im & 32'hFFF) << 20) | v1 | v3 | vd | o;
                r.err  = (si < -2048) || (si > 2047);
            end
            3'd2: begin
                r.inst = (((im >> 5) & 32'h7F) << 25) | v2 | v1 | v3 | ((im & 32'h1F) << 7) | o;
                r.err  = (si < -2048) || (si > 2047);
            end
            3'd3: begin
                r.inst = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | v2 | v1
                       | v3 | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | o;
                r.err  = (si < -4096) || (si > 4095) || (im[0] == 1'b1);
            end
            3'd4: begin
                r.inst = (im & 32'hFFFFF000) | vd | o;
                r.err  = (im & 32'hFFF) != 0;
            end
            3'd5: begin
                r.inst = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                       | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | vd | o;
                r.err  = (si < -1048576) || (si > 1048575) || (im[0] == 1'b1);
            end
            3'd6: begin
                r.inst = v7 | v2 | ((im & 32'h1F) << 15) | v3 | vd | o;
                r.err  = im > 32'd31;
            end
            default: begin r.inst = o; r.err = 1'b1; end
        endcase
        if (!Chk) r.err = 1'b0;
        return r;
    endfunction

    // Scoreboard: accepted requests queued in order, popped on output handshakes.
    exp_t        q[$];
    int unsigned m_cnt = 0;
    bit          armed = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_inst = '0;
    logic        prev_err = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (armed) begin
            check("err_cnt", 32'(err_cnt), 32'(m_cnt));
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_inst", inst, prev_inst);
                check("hold_err", 32'(err), 32'(prev_err));
            end
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    check("out_inst", inst, e.inst);
                    check("out_err", 32'(err), 32'(e.err));
                    if (e.err && m_cnt != CntMax) m_cnt++;
                end
            end
            if (!rst && in_valid && in_ready) begin
                q.push_back(model(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm));
            end
        end
        prev_stall = armed && !rst && out_valid && !out_ready;
        prev_inst  = inst;
        prev_err   = err;
        if (rst) begin
            q.delete();
            m_cnt = 0;
            armed = 1'b1;
        end
    end

    task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                           input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] im);
        fmt = f; opcode = op; rd = d; rs1 = a; rs2 = b; funct3 = f3; funct7 = f7; imm = im;
    endtask

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic offer(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] im);
        int k;
        k = 0;
        set_req(f, op, d, a, b, f3, f7, im);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("offer_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [31:0] i_exp, input logic e_exp);
        int k;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_inst"}, inst, i_exp);
        check({name, "_err"}, 32'(err), 32'(e_exp));
    endtask

    function automatic logic [31:0] pick_imm();
        int tbl[16] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098,
                        1048574, 1048576, -1048576, -1048578, 31, 32, 0};
        case ($urandom_range(0, 4))
            0:       return $urandom;
            1:       return 32'($signed($urandom_range(0, 8191)) - 4096);
            2:       return 32'(tbl[$urandom_range(0, 15)]);
            3:       return $urandom & 32'hFFFFF000;
            default: return 32'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // I-type with all-ones immediate; latency from accept to out_valid.
        @(posedge clk); #1;
        offer(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
        @(negedge clk);
        check("i_lat1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("i_lat2_valid", 32'(out_valid), 32'd1);
        check("i_inst", inst, 32'hFFF10093);
        check("i_err", 32'(err), 32'd0);

        // Branch: aligned and odd offset.
        @(posedge clk); #1;
        offer(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
        expect_out("b_even", 32'h00208463, 1'b0);
        @(posedge clk); #1;
        offer(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7);
        expect_out("b_odd", 32'h00208363, Chk);
        @(negedge clk);
        check("b_err_cnt", 32'(err_cnt), Chk ? 32'd1 : 32'd0);

        // Upper immediate: clean and with low bits set.
        @(posedge clk); #1;
        offer(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        expect_out("u_ok", 32'h123452B7, 1'b0);
        @(posedge clk); #1;
        offer(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001);
        expect_out("u_bad", 32'h123452B7, Chk);

        // Reserved format keeps only the opcode.
        @(posedge clk); #1;
        offer(3'd7, 7'h33, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'hFFFFFFFF);
        expect_out("rsvd", 32'h00000033, Chk);
        @(negedge clk);
        check("rsvd_err_cnt", 32'(err_cnt), Chk ? 32'd3 : 32'd0);

        // Backpressure: three offered, two accepted, then released in order.
        @(posedge clk); #1;
        out_ready = 1'b0;
        set_req(3'd0, 7'h33, 5'd5, 5'd4, 5'd3, 3'd0, 7'h20, 32'd0);
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_ready_a", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        set_req(3'd1, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        @(negedge clk);
        check("bp_ready_b", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        set_req(3'd2, 7'h23, 5'd0, 5'd2, 5'd7, 3'd2, 7'd0, 32'd8);
        @(negedge clk);
        check("bp_ready_c0", 32'(in_ready), 32'd0);
        check("bp_inst_a", inst, 32'h403202B3);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_ready_c1", 32'(in_ready), 32'd0);
        check("bp_hold_a", inst, 32'h403202B3);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_rel", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_inst_b", inst, 32'h00500313);
        @(negedge clk);
        check("bp_inst_c", inst, 32'h00712423);

        // Reset with both stages full.
        @(posedge clk); #1;
        out_ready = 1'b0;
        offer(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd5);
        offer(3'd7, 7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        @(negedge clk);
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_err_cnt", 32'(err_cnt), Chk ? 32'd3 : 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        set_req(3'd1, 7'h13, 5'd3, 5'd3, 5'd0, 3'd0, 7'd0, 32'd1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_inst", inst, 32'd0);
        @(negedge clk);
        check("mid_rst_no_capture", 32'(out_valid), 32'd0);

        // Counter saturation.
        @(posedge clk); #1;
        set_req(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd1);
        in_valid = 1'b1;
        repeat (262) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("sat_cnt", 32'(err_cnt), Chk ? 32'd255 : 32'd0);
        @(posedge clk); #1;
        offer(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        expect_out("sat_word", 32'h00000013, Chk);
        @(negedge clk);
        check("sat_hold", 32'(err_cnt), Chk ? 32'd255 : 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;

        // Randomized traffic, backpressure and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 499) == 0);
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 65);
            set_req(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                    5'($urandom), 3'($urandom), 7'($urandom), pick_imm());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("drain_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
